// File: rtl/sd_pkg.sv
// Shared SD-card SPI constants and types for the block write/read controllers.
package sd_pkg;

  localparam logic [7:0] CMD24_IDX    = 8'h58;
  localparam logic [7:0] START_TOKEN  = 8'hFE;
  localparam logic [4:0] DRESP_ACCEPT = 5'b00101;

  localparam int BLOCK_BYTES = 512;
  localparam int WORD_BITS   = 16;
  localparam int BLOCK_WORDS = BLOCK_BYTES / (WORD_BITS / 8);
  localparam int SHIFT_W     = 48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_R1,
    ST_GAP,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_DRESP,
    ST_BUSY,
    ST_POST,
    ST_ERR
  } wr_state_t;

  // Full 48-bit CMD24 frame: index, sector address, dummy CRC with stop bit.
  function automatic logic [SHIFT_W-1:0] cmd24_frame(input logic [31:0] addr);
    return {CMD24_IDX, addr, 8'hFF};
  endfunction

endpackage

// File: rtl/sd_write_ctrl_if.sv
// Handshake between the test-data generator (master) and the write controller (slave).
interface sd_write_ctrl_if;
  import sd_pkg::*;

  logic                 wr_start_en;
  logic [31:0]          wr_sec_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic                 wr_busy;
  logic                 wr_req;
  logic                 wr_err;

  modport master (
    output wr_start_en, wr_sec_addr, wr_data,
    input  wr_busy, wr_req, wr_err
  );

  modport slave (
    input  wr_start_en, wr_sec_addr, wr_data,
    output wr_busy, wr_req, wr_err
  );
endinterface

// File: rtl/sd_spi_shift.sv
// MSB-first load/shift-out register with a bit counter, shared by CMD, TOKEN and DATA.
module sd_spi_shift
  import sd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [SHIFT_W-1:0] load_val,
  output logic               bit_out,
  output logic [5:0]         bit_cnt
);

  logic [SHIFT_W-1:0] sr;

  // A load restarts the bit count; shifting backfills with ones so idle MOSI stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '1;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= load_val;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= {sr[SHIFT_W-2:0], 1'b1};
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign bit_out = sr[SHIFT_W-1];

endmodule

// File: rtl/sd_write_ctrl.sv
// SPI-mode CMD24 single-block write controller: command, R1, token, data, response, busy.
module sd_write_ctrl
  import sd_pkg::*;
#(
  parameter int WORDS        = BLOCK_WORDS,
  parameter int RESP_TIMEOUT = 255,
  parameter int BUSY_TIMEOUT = 1_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  sd_write_ctrl_if.slave wr,
  input  logic           sd_miso,
  output logic           sd_cs,
  output logic           sd_mosi
);

  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(WORDS - 1);
  localparam logic [19:0]       RESP_LIMIT = 20'(RESP_TIMEOUT - 1);
  localparam logic [19:0]       BUSY_LIMIT = 20'(BUSY_TIMEOUT - 1);

  wr_state_t          state, next_state;
  logic [31:0]        addr_q;
  logic [3:0]         seq_cnt;
  logic [19:0]        tmo_cnt;
  logic [WCNT_W-1:0]  word_cnt;
  logic               rx_on;
  logic [7:0]         rx_sr;
  logic [7:0]         rx_val;
  logic               err_q;

  logic               sh_load, sh_shift, sh_bit;
  logic [SHIFT_W-1:0] sh_val;
  logic [5:0]         sh_cnt;

  sd_spi_shift u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .bit_out  (sh_bit),
    .bit_cnt  (sh_cnt)
  );

  // Byte as it will look once the bit currently on MISO is shifted in.
  assign rx_val = {rx_sr[6:0], sd_miso};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic and shifter control; the next item is loaded on the last bit of the current one.
  always_comb begin
    next_state = state;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_val     = '1;
    case (state)
      ST_IDLE:  if (wr.wr_start_en) next_state = ST_PRE;
      ST_PRE: begin
        if (seq_cnt == 4'd7) begin
          next_state = ST_CMD;
          sh_load    = 1'b1;
          sh_val     = cmd24_frame(addr_q);
        end
      end
      ST_CMD: begin
        sh_shift = 1'b1;
        if (sh_cnt == 6'd47) next_state = ST_R1;
      end
      ST_R1: begin
        if (rx_on) begin
          if (seq_cnt == 4'd7) next_state = (rx_val == 8'h00) ? ST_GAP : ST_ERR;
        end else if (sd_miso && tmo_cnt == RESP_LIMIT) begin
          next_state = ST_ERR;
        end
      end
      ST_GAP: begin
        if (seq_cnt == 4'd7) begin
          next_state = ST_TOKEN;
          sh_load    = 1'b1;
          sh_val     = {START_TOKEN, {(SHIFT_W-8){1'b1}}};
        end
      end
      ST_TOKEN: begin
        if (sh_cnt == 6'd7) begin
          next_state = ST_DATA;
          sh_load    = 1'b1;
          sh_val     = {wr.wr_data, {(SHIFT_W-WORD_BITS){1'b1}}};
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_DATA: begin
        if (sh_cnt == 6'd15) begin
          if (word_cnt == LAST_WORD) begin
            next_state = ST_CRC;
          end else begin
            sh_load = 1'b1;
            sh_val  = {wr.wr_data, {(SHIFT_W-WORD_BITS){1'b1}}};
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_CRC:   if (seq_cnt == 4'd15) next_state = ST_DRESP;
      ST_DRESP: begin
        if (rx_on) begin
          if (seq_cnt == 4'd4) next_state = (rx_val[4:0] == DRESP_ACCEPT) ? ST_BUSY : ST_ERR;
        end else if (sd_miso && tmo_cnt == BUSY_LIMIT) begin
          next_state = ST_ERR;
        end
      end
      ST_BUSY: begin
        if (sd_miso)                     next_state = ST_POST;
        else if (tmo_cnt == BUSY_LIMIT)  next_state = ST_ERR;
      end
      ST_ERR:   next_state = ST_POST;
      ST_POST:  if (seq_cnt == 4'd7) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Per-state counters and the MISO receive shifter; everything restarts on a state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt  <= '0;
      tmo_cnt  <= '0;
      word_cnt <= '0;
      rx_on    <= 1'b0;
      rx_sr    <= '0;
    end else if (next_state != state) begin
      seq_cnt  <= '0;
      tmo_cnt  <= '0;
      word_cnt <= '0;
      rx_on    <= 1'b0;
    end else begin
      case (state)
        ST_R1, ST_DRESP: begin
          if (!rx_on) begin
            if (!sd_miso) begin
              rx_on   <= 1'b1;
              rx_sr   <= '0;
              seq_cnt <= 4'd1;
            end else begin
              tmo_cnt <= tmo_cnt + 20'd1;
            end
          end else begin
            rx_sr   <= rx_val;
            seq_cnt <= seq_cnt + 4'd1;
          end
        end
        ST_BUSY: tmo_cnt <= tmo_cnt + 20'd1;
        ST_DATA: if (sh_cnt == 6'd15) word_cnt <= word_cnt + 1'b1;
        default: seq_cnt <= seq_cnt + 4'd1;
      endcase
    end
  end

  // Sector address capture and sticky error flag, both refreshed by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else if (state == ST_IDLE && wr.wr_start_en) begin
      addr_q <= wr.wr_sec_addr;
      err_q  <= 1'b0;
    end else if (state == ST_ERR) begin
      err_q  <= 1'b1;
    end
  end

  assign wr.wr_busy = (state != ST_IDLE);
  assign wr.wr_err  = err_q;
  assign wr.wr_req  = (state == ST_TOKEN && sh_cnt == 6'd6) ||
                      (state == ST_DATA && sh_cnt == 6'd14 && word_cnt != LAST_WORD);
  assign sd_cs      = (state == ST_IDLE) || (state == ST_POST);
  assign sd_mosi    = (state == ST_CMD || state == ST_TOKEN || state == ST_DATA) ? sh_bit : 1'b1;

endmodule
